emern_inverse_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single combinational reciprocal unit (13-bit determinant in, 23-bit magnitude plus sign out) between several triangle-setup requesters. It registers the selected determinant onto the unit's input. It waits a fixed number of settle cycles for the multicycle-constrained combinational path, then captures the result. Finally, it returns the result on a tagged response channel with backpressure.

---
 rtl/emern_inverse_arbiter.sv | 146 ++++++++++++++
 tb/tb_emern_inverse_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/emern_inverse_arbiter.sv
// Round-robin arbiter/sequencer sharing one multicycle combinational reciprocal unit.
// Optional `INV_ARB_ZERO_DET_EN: zero determinants bypass the unit with a saturated result.
module emern_inverse_arbiter #(
  parameter  int NUM_REQ       = 4,
  parameter  int DET_W         = 13,
  parameter  int INV_W         = 23,
  parameter  int SETTLE_CYCLES = 2,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DET_W-1:0] req_det,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [INV_W-1:0]         rsp_inv,
  output logic                     rsp_neg,
  output logic [DET_W-1:0]         inv_determinant,
  input  logic [INV_W-1:0]         inv_result,
  input  logic                     inv_negative
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DET_W-1:0]   det_q, det_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [INV_W-1:0]   rsp_inv_q, rsp_inv_d;
  logic               rsp_neg_q, rsp_neg_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic [ID_W-1:0]    grant;
  logic               grant_found;
  logic [DET_W-1:0]   grant_det;

  // Index arithmetic modulo NUM_REQ, with the wrap written out so non-power-of-two counts work.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[ID_W-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest valid requester at or after ptr wins.
  always_comb begin
    grant       = ptr_q;
    grant_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[wrap_add(ptr_q, i)]) begin
        grant       = wrap_add(ptr_q, i);
        grant_found = 1'b1;
      end
    end
  end

  assign grant_det = req_det[grant*DET_W +: DET_W];

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found && !rst) req_ready[grant] = 1'b1;
  end

  // NOTE: every _d starts from its _q so no path through this block leaves a value unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    det_d       = det_q;
    rsp_id_d    = rsp_id_q;
    rsp_inv_d   = rsp_inv_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          det_d    = grant_det;
          rsp_id_d = grant;
          ptr_d    = wrap_add(grant, 1);
          cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
          state_d  = SETTLE;
`ifdef INV_ARB_ZERO_DET_EN
          if (grant_det == '0) begin
            rsp_inv_d   = '1;
            rsp_neg_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
`endif
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          rsp_inv_d   = inv_result;
          rsp_neg_d   = inv_negative;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      det_q       <= '0;
      rsp_id_q    <= '0;
      rsp_inv_q   <= '0;
      rsp_neg_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      det_q       <= det_d;
      rsp_id_q    <= rsp_id_d;
      rsp_inv_q   <= rsp_inv_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_inv         = rsp_inv_q;
  assign rsp_neg         = rsp_neg_q;
  assign inv_determinant = det_q;

endmodule

// File: tb/tb_emern_inverse_arbiter.sv
// Self-checking bench for emern_inverse_arbiter: directed steps then randomized transactions
// against a transaction-level round-robin model and a behavioural reciprocal unit.
module tb_emern_inverse_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int DET_W         = 13;
  localparam int INV_W         = 23;
  localparam int SETTLE_CYCLES = 2;
  localparam int ID_W          = $clog2(NUM_REQ);

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*DET_W-1:0] req_det = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [ID_W-1:0]          rsp_id;
  logic [INV_W-1:0]         rsp_inv;
  logic                     rsp_neg;
  logic [DET_W-1:0]         inv_determinant;
  logic [INV_W-1:0]         inv_result;
  logic                     inv_negative;

  int n_cmp = 0;
  int n_err = 0;
  int tb_ptr = 0;

  emern_inverse_arbiter #(
    .NUM_REQ(NUM_REQ), .DET_W(DET_W), .INV_W(INV_W), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_det(req_det), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_inv(rsp_inv), .rsp_neg(rsp_neg),
    .inv_determinant(inv_determinant), .inv_result(inv_result), .inv_negative(inv_negative)
  );

  always #5 clk = ~clk;

  // Behavioural reciprocal unit: {sign, 2^(INV_W-1)/|det|}; zero gives an arbitrary marker.
  function automatic logic [INV_W:0] unit_model(input logic [DET_W-1:0] det);
    int v;
    int mag;
    if (det == '0) return {1'b1, INV_W'(23'h2AAAAA)};
    v   = int'($signed(det));
    mag = (v < 0) ? -v : v;
    return {det[DET_W-1], INV_W'((1 << (INV_W - 1)) / mag)};
  endfunction

  assign {inv_negative, inv_result} = unit_model(inv_determinant);

  function automatic logic [INV_W:0] exp_rsp(input logic [DET_W-1:0] det);
`ifdef INV_ARB_ZERO_DET_EN
    if (det == '0) return {1'b0, {INV_W{1'b1}}};
`endif
    return unit_model(det);
  endfunction

  // Edges after the acceptance edge until rsp_valid is seen.
  function automatic int exp_lat(input logic [DET_W-1:0] det);
`ifdef INV_ARB_ZERO_DET_EN
    if (det == '0) return 0;
`endif
    return SETTLE_CYCLES;
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] valid, input int ptr);
    for (int off = 0; off < NUM_REQ; off++) begin
      if (valid[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [DET_W-1:0] det);
    req_valid[i]               = v;
    req_det[i*DET_W +: DET_W] = det;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    check({tag, "_rsp_inv"}, 32'(rsp_inv), 0);
    check({tag, "_rsp_neg"}, 32'(rsp_neg), 0);
    check({tag, "_inv_det"}, 32'(inv_determinant), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
  endtask

  // One full transaction from IDLE: grant, settle, response with bp cycles of backpressure.
  task automatic run_txn(input int bp, input int want, output int g);
    logic [DET_W-1:0] det;
    logic [INV_W:0]   er;
    int               lat;
    int               n;
    g   = (want >= 0) ? want : rr_pick(req_valid, tb_ptr);
    det = req_det[g*DET_W +: DET_W];
    er  = exp_rsp(det);
    lat = exp_lat(det);
    rsp_ready = (bp == 0);
    #1;
    check("req_ready_grant", 32'(req_ready), 32'(1 << g));
    @(posedge clk);
    tb_ptr = (g + 1) % NUM_REQ;
    #1;
    check("inv_determinant", 32'(inv_determinant), 32'(det));
    check("req_ready_busy", 32'(req_ready), 0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, lat);
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_inv", 32'(rsp_inv), 32'(er[INV_W-1:0]));
    check("rsp_neg", 32'(rsp_neg), 32'(er[INV_W]));
    for (int b = 0; b < bp; b++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_inv", 32'(rsp_inv), 32'(er[INV_W-1:0]));
      check("bp_rsp_id", 32'(rsp_id), 32'(g));
      check("bp_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("resp_exit_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    check("resp_done", 32'(rsp_valid), 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int g;
    int nv;

    // Reset values, then abort a transaction mid-SETTLE.
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1'b1, 13'd4);
    #1;
    check("req_ready_in_rst", 32'(req_ready), 0);
    set_req(0, 1'b0, '0);
    rst = 1'b0;
    #1;
    check_reset_outputs("post_rst");
    set_req(0, 1'b1, 13'd4);
    #1;
    check("first_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    check("settle_det", 32'(inv_determinant), 4);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_settle_rst");
    set_req(0, 1'b0, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_ptr = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("no_rsp_after_rst", 32'(rsp_valid), 0);
      check("idle_no_req", 32'(req_ready), 0);
    end

    // Round robin with all four requesters held valid.
    set_req(0, 1'b1, 13'd1);
    set_req(1, 1'b1, 13'd2);
    set_req(2, 1'b1, 13'd3);
    set_req(3, 1'b1, 13'h1FFB);
    run_txn(0, 0, g);
    run_txn(0, 1, g);
    run_txn(0, 2, g);
    run_txn(0, 3, g);
    run_txn(0, 0, g);
    req_valid = '0;

    // Single request wrapping from ptr=1 back to requester 0.
    set_req(0, 1'b1, 13'd4);
    run_txn(0, 0, g);
    req_valid = '0;

    // Ten cycles of backpressure.
    set_req(2, 1'b1, 13'd100);
    run_txn(10, 2, g);
    req_valid = '0;

    // ptr is 3: requester 3 goes before requester 1.
    set_req(1, 1'b1, 13'd9);
    set_req(3, 1'b1, 13'h1F00);
    run_txn(0, 3, g);
    run_txn(0, 1, g);
    req_valid = '0;

    // Zero determinant at ptr=2.
    set_req(2, 1'b1, '0);
    run_txn(1, 2, g);
    req_valid = '0;

    // Randomized traffic; requesters stay valid until served.
    for (int t = 0; t < 30; t++) begin
      nv = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          set_req(i, 1'b1, ($urandom_range(7, 0) == 0) ? '0 : DET_W'($urandom));
        end
        if (req_valid[i]) nv++;
      end
      if (nv == 0) set_req(t % NUM_REQ, 1'b1, DET_W'($urandom));
      run_txn(int'($urandom_range(3, 0)), -1, g);
      if (g >= 0 && g < NUM_REQ) req_valid[g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
